// File: rtl/mem_ctrl.sv
// Load/store controller between the CPU load/store unit and a 1-cycle-latency
// word-addressed memory port; sub-word stores are read-modify-write.
module mem_ctrl #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          mem_rw,
  output logic [AW-1:0] mem_ain,
  output logic [31:0]   mem_din,
  input  logic [31:0]   mem_dout
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  typedef enum logic [2:0] {IDLE, RD, RDW, WR, RESP, ERR} state_t;

  // Only the request fields still needed after acceptance are kept.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lane;
    logic [15:0] wdata;
  } req_t;

  state_t        state, state_d;
  req_t          req_q, req_d;
  logic [AW-1:0] ain_q, ain_d;
  logic [31:0]   din_q, din_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          resp_valid_q, resp_err_q;
  logic          bad_c;
  logic [7:0]    byte_c;
  logic [15:0]   half_c;
  logic [31:0]   load_c, merge_c;

  assign bad_c = (req_size == 2'd3)
               | ((req_size == 2'd1) & req_addr[0])
               | ((req_size == 2'd2) & (|req_addr[1:0]))
               | (req_addr >= ADDR_LIMIT);

  // Lane extraction / extension for loads and lane merge for sub-word stores.
  always_comb begin
    byte_c  = mem_dout[{req_q.lane, 3'b000} +: 8];
    half_c  = mem_dout[{req_q.lane[1], 4'b0000} +: 16];
    load_c  = mem_dout;
    merge_c = mem_dout;
    case (req_q.size)
      2'd0: begin
        load_c = req_q.uns ? {24'd0, byte_c} : {{24{byte_c[7]}}, byte_c};
        merge_c[{req_q.lane, 3'b000} +: 8] = req_q.wdata[7:0];
      end
      2'd1: begin
        load_c = req_q.uns ? {16'd0, half_c} : {{16{half_c[15]}}, half_c};
        merge_c[{req_q.lane[1], 4'b0000} +: 16] = req_q.wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state;
    req_d   = req_q;
    ain_d   = ain_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          req_d   = '{we: req_we, size: req_size, uns: req_unsigned,
                      lane: req_addr[1:0], wdata: req_wdata[15:0]};
          ain_d   = req_addr[AW+1:2];
          rdata_d = '0;
          if (bad_c) begin
            state_d = ERR;
          end else if (req_we && req_size == 2'd2) begin
            din_d   = req_wdata;
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:  state_d = RDW;
      RDW: begin
        if (req_q.we) begin
          din_d   = merge_c;
          state_d = WR;
        end else begin
          rdata_d = load_c;
          state_d = RESP;
        end
      end
      WR:        state_d = RESP;
      RESP, ERR: if (resp_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      req_q        <= '0;
      ain_q        <= '0;
      din_q        <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state        <= state_d;
      req_q        <= req_d;
      ain_q        <= ain_d;
      din_q        <= din_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= (state_d == RESP) || (state_d == ERR);
      resp_err_q   <= (state_d == ERR);
    end
  end

  // Handshake ready and write strobe follow the state register directly.
  assign req_ready  = (state == IDLE);
  assign mem_rw     = (state == WR);
  assign mem_ain    = ain_q;
  assign mem_din    = din_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized bench for mem_ctrl: behavioural memory plus an arithmetic reference model.
module tb_mem_ctrl;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [31:0]   resp_rdata;
  logic          mem_rw;
  logic [AW-1:0] mem_ain;
  logic [31:0]   mem_din, mem_dout;

  logic [31:0] tb_mem  [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int total = 0;
  int bad   = 0;

  mem_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_rw(mem_rw),
    .mem_ain(mem_ain), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clock = ~clock;

  // Synchronous memory, read-first, one cycle read latency.
  always @(posedge clock) begin
    if (mem_rw) tb_mem[mem_ain] <= mem_din;
    mem_dout <= tb_mem[mem_ain];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: decides error, latency, write count and load value from the rules.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic err, output logic [31:0] rdata,
                       output int lat, output int nrw);
    int unsigned idx, off, w, v, mask;
    err = (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0)
          || (addr >= 4 * DEPTH);
    idx = (addr / 4) % DEPTH;
    off = addr % 4;
    rdata = 32'd0;
    if (err) begin
      lat = 1; nrw = 0;
    end else if (!we) begin
      w = ref_mem[idx];
      if (size == 2) v = w;
      else if (size == 0) begin
        v = (w >> (8 * off)) & 32'hFF;
        if (!uns && v >= 128) v = v - 256;
      end else begin
        v = (w >> (8 * off)) & 32'hFFFF;
        if (!uns && v >= 32768) v = v - 65536;
      end
      rdata = v; lat = 3; nrw = 0;
    end else begin
      mask = (size == 0) ? 32'hFF : (size == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
      ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
      lat = (size == 2) ? 2 : 4; nrw = 1;
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, output logic [31:0] got);
    logic        e_err;
    logic [31:0] e_rdata;
    int          e_lat, e_rw, lat, nrw;
    model(we, size, uns, addr, wdata, e_err, e_rdata, e_lat, e_rw);
    @(negedge clock);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clock);
    // Busy-time inputs are garbage and must be ignored.
    req_valid = 1'b1; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 1; nrw = 0;
    while (!resp_valid && lat < 16) begin
      if (mem_rw) nrw++;
      @(negedge clock);
      lat++;
    end
    check("latency", 32'(lat), 32'(e_lat));
    check("resp_err", 32'(resp_err), 32'(e_err));
    check("resp_rdata", resp_rdata, e_rdata);
    got = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (mem_rw) nrw++;
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, e_rdata);
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    check("mem_rw_cycles", 32'(nrw), 32'(e_rw));
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0; req_valid = 1'b0;
    check("resp_done", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] got, v;
    int diff;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom; tb_mem[i] = v; ref_mem[i] = v;
    end
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_we = 1'b0;
    req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    @(negedge clock);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_rw", 32'(mem_rw), 32'd0);
    check("rst_ain", 32'(mem_ain), 32'd0);
    check("rst_din", mem_din, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    do_req(1, 2, 0, 32'h10, 32'h1122_3344, 0, got);
    do_req(0, 2, 0, 32'h10, 32'h0, 0, got);
    check("lw_dir", got, 32'h1122_3344);
    do_req(1, 2, 0, 32'h20, 32'h1122_3380, 0, got);
    do_req(0, 0, 0, 32'h20, 32'h0, 0, got);
    check("lb_dir", got, 32'hFFFF_FF80);
    do_req(0, 0, 1, 32'h20, 32'h0, 0, got);
    check("lbu_dir", got, 32'h0000_0080);
    do_req(0, 1, 0, 32'h22, 32'h0, 3, got);
    check("lh_dir", got, 32'h0000_1122);
    do_req(1, 0, 0, 32'h12, 32'hFFFF_FFAA, 0, got);
    do_req(0, 2, 0, 32'h10, 32'h0, 0, got);
    check("sb_dir", got, 32'h11AA_3344);
    do_req(1, 2, 0, 32'h10, 32'h1122_3344, 0, got);
    do_req(1, 1, 0, 32'h10, 32'h1234_BEEF, 0, got);
    do_req(0, 2, 0, 32'h10, 32'h0, 0, got);
    check("sh_dir", got, 32'h1122_BEEF);
    do_req(0, 2, 0, 32'h02, 32'h0, 1, got);
    do_req(1, 1, 0, 32'h01, 32'h1, 0, got);
    do_req(0, 3, 0, 32'h04, 32'h0, 0, got);
    do_req(0, 2, 0, 32'h1000, 32'h0, 0, got);

    // Reset in the RDW cycle of a byte store must not write memory.
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h31; req_wdata = 32'h0000_0055;
    @(negedge clock);
    req_valid = 1'b0;
    check("rmw_rd_rw", 32'(mem_rw), 32'd0);
    @(negedge clock);
    check("rmw_rdw_rw", 32'(mem_rw), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_async_rw", 32'(mem_rw), 32'd0);
    check("rst_async_ready", 32'(req_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_after_rw", 32'(mem_rw), 32'd0);
    check("rst_after_ready", 32'(req_ready), 32'd1);
    check("rst_word", tb_mem[12], ref_mem[12]);
    do_req(0, 2, 0, 32'h30, 32'h0, 0, got);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
             int'($urandom_range(0, 3)), got);
    end

    diff = 0;
    for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== ref_mem[i]) diff++;
    check("mem_final", 32'(diff), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
